// File: rtl/tank_sensor_filter.sv
// Float-switch conditioner: two-flop synchroniser, per-channel debounce, warm-up flag,
// and a plausibility FSM that forces a safe "full" reading while a fault is latched.
module tank_sensor_filter #(
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int FAULT_CYCLES    = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic I_raw,
    input  logic S_raw,
    output logic I,
    output logic S,
    output logic fault,
    output logic valid
);
    localparam int DB_W      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int FT_W      = (FAULT_CYCLES > 1) ? $clog2(FAULT_CYCLES) : 1;
    localparam int WARM_LAST = DEBOUNCE_CYCLES + 2;
    localparam int WARM_W    = $clog2(WARM_LAST + 1);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [FT_W-1:0]   FT_LAST   = FT_W'(FAULT_CYCLES - 1);
    localparam logic [WARM_W-1:0] WARM_DONE = WARM_W'(WARM_LAST);

    typedef enum logic [1:0] {
        ST_OK,
        ST_SUSPECT,
        ST_FAULT,
        ST_RECOVER
    } state_t;

    // Channel index 0 is the lower switch (I), index 1 the upper switch (S).
    logic [1:0]      sync1;
    logic [1:0]      sync2;
    logic [1:0]      filt;
    logic [DB_W-1:0] db_cnt [2];

    logic [WARM_W-1:0] warm_cnt;

    state_t          state;
    logic [FT_W-1:0] timer;
    logic            bad;

    // Both channels share one block but never interact; each has its own counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 2'b11;
            sync2 <= 2'b11;
            filt  <= 2'b11;
            for (int ch = 0; ch < 2; ch++) begin
                db_cnt[ch] <= '0;
            end
        end else begin
            sync1 <= {S_raw, I_raw};
            sync2 <= sync1;
            for (int ch = 0; ch < 2; ch++) begin
                if (sync2[ch] == filt[ch]) begin
                    db_cnt[ch] <= '0;
                end else if (db_cnt[ch] == DB_LAST) begin
                    filt[ch]   <= sync2[ch];
                    db_cnt[ch] <= '0;
                end else begin
                    db_cnt[ch] <= db_cnt[ch] + DB_W'(1);
                end
            end
        end
    end

    // Warm-up covers the synchroniser plus one full debounce window, then saturates.
    always_ff @(posedge clk) begin
        if (reset) begin
            warm_cnt <= '0;
        end else if (warm_cnt != WARM_DONE) begin
            warm_cnt <= warm_cnt + WARM_W'(1);
        end
    end

    assign valid = (warm_cnt == WARM_DONE);

    // Upper wet while lower dry cannot happen physically.
    assign bad = !filt[0] && filt[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_OK;
            timer <= '0;
        end else begin
            case (state)
                ST_OK: begin
                    if (bad) begin
                        state <= ST_SUSPECT;
                        timer <= '0;
                    end
                end
                ST_SUSPECT: begin
                    if (!bad) begin
                        state <= ST_OK;
                    end else if (timer == FT_LAST) begin
                        state <= ST_FAULT;
                        timer <= '0;
                    end else begin
                        timer <= timer + FT_W'(1);
                    end
                end
                ST_FAULT: begin
                    if (!bad) begin
                        state <= ST_RECOVER;
                        timer <= '0;
                    end
                end
                ST_RECOVER: begin
                    if (bad) begin
                        state <= ST_FAULT;
                        timer <= '0;
                    end else if (timer == FT_LAST) begin
                        state <= ST_OK;
                        timer <= '0;
                    end else begin
                        timer <= timer + FT_W'(1);
                    end
                end
                default: begin
                    state <= ST_OK;
                    timer <= '0;
                end
            endcase
        end
    end

    // A latched fault presents "full" so the pump controller keeps both pumps off.
    assign fault = (state == ST_FAULT) || (state == ST_RECOVER);
    assign I     = fault | filt[0];
    assign S     = fault | filt[1];

endmodule

// File: tb/tb_tank_sensor_filter.sv
// Directed bench for tank_sensor_filter; edge n means the n-th rising edge after
// the inputs were last driven, with outputs sampled 1 ns after that edge.
module tb_tank_sensor_filter;
    logic clk = 1'b0;
    logic reset;
    logic I_raw;
    logic S_raw;
    logic I;
    logic S;
    logic fault;
    logic valid;

    int testsRun    = 0;
    int testsFailed = 0;

    tank_sensor_filter #(
        .DEBOUNCE_CYCLES(8),
        .FAULT_CYCLES(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .I_raw(I_raw),
        .S_raw(S_raw),
        .I(I),
        .S(S),
        .fault(fault),
        .valid(valid)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic observed, input logic expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %b, expected %b", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string phase, input int n, input logic expI, input logic expS,
                            input logic expFault, input logic expValid);
        checkOutput($sformatf("%s I e%0d", phase, n), I, expI);
        checkOutput($sformatf("%s S e%0d", phase, n), S, expS);
        checkOutput($sformatf("%s fault e%0d", phase, n), fault, expFault);
        checkOutput($sformatf("%s valid e%0d", phase, n), valid, expValid);
    endtask

    task automatic applyStimulus(input logic iVal, input logic sVal);
        I_raw = iVal;
        S_raw = sVal;
    endtask

    task automatic stepEdge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(1'b1, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Warm-up: outputs safe immediately, valid rises at edge 10.
        checkAll("reset", 0, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int n = 1; n <= 10; n++) begin
            stepEdge();
            checkAll("warmup", n, 1'b1, 1'b1, 1'b0, (n >= 10));
        end

        // Five-cycle glitch on the lower switch must be swallowed.
        applyStimulus(1'b0, 1'b1);
        for (int n = 1; n <= 15; n++) begin
            stepEdge();
            if (n == 5) applyStimulus(1'b1, 1'b1);
            checkAll("glitch5", n, 1'b1, 1'b1, 1'b0, 1'b1);
        end

        // Seven-cycle glitch is one short of the debounce window.
        applyStimulus(1'b0, 1'b1);
        for (int n = 1; n <= 15; n++) begin
            stepEdge();
            if (n == 7) applyStimulus(1'b1, 1'b1);
            checkAll("glitch7", n, 1'b1, 1'b1, 1'b0, 1'b1);
        end

        // Held implausible pair: I falls at 10, fault forces (1,1) at 27.
        applyStimulus(1'b0, 1'b1);
        for (int n = 1; n <= 27; n++) begin
            stepEdge();
            checkAll("fault", n, (n >= 27) ? 1'b1 : ((n >= 10) ? 1'b0 : 1'b1),
                     1'b1, (n >= 27), 1'b1);
        end

        // Restore: RECOVER entered at 11, fault clears 16 edges later.
        applyStimulus(1'b1, 1'b1);
        for (int n = 1; n <= 30; n++) begin
            stepEdge();
            checkAll("recover", n, 1'b1, 1'b1, (n <= 26), 1'b1);
        end

        // Implausible for only 10 filtered cycles: SUSPECT then OK, no fault.
        applyStimulus(1'b0, 1'b1);
        for (int n = 1; n <= 40; n++) begin
            stepEdge();
            if (n == 10) applyStimulus(1'b1, 1'b1);
            checkAll("suspect", n, (n >= 10 && n < 20) ? 1'b0 : 1'b1, 1'b1, 1'b0, 1'b1);
        end

        // Drive into FAULT, then RECOVER with an S debounce in progress.
        applyStimulus(1'b0, 1'b1);
        for (int n = 1; n <= 27; n++) begin
            stepEdge();
        end
        checkOutput("pre-reset fault e27", fault, 1'b1);
        applyStimulus(1'b1, 1'b1);
        for (int n = 1; n <= 18; n++) begin
            stepEdge();
            if (n == 13) applyStimulus(1'b1, 1'b0);
        end
        checkOutput("pre-reset recover fault", fault, 1'b1);
        checkOutput("pre-reset recover S", S, 1'b1);

        // Mid-RECOVER reset discards debounce, fault and warm-up progress.
        reset = 1'b1;
        stepEdge();
        reset = 1'b0;
        checkAll("midreset", 0, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int n = 1; n <= 12; n++) begin
            stepEdge();
            checkAll("midreset", n, 1'b1, (n >= 10) ? 1'b0 : 1'b1, 1'b0, (n >= 10));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
